cordic_freq_disc: RTL

Phase-difference frequency discriminator placed directly downstream of `cordic`. It consumes the `cordic` amplitude/phase stream through a valid/ready handshake. It differentiates successive phases modulo 2π and averages 2^LOG2_N differences and amplitudes. It emits one frequency/amplitude pair per block through a registered valid/ready output.

---
 rtl/cordic_freq_disc.sv | 76 +++++++
 1 files changed

// File: rtl/cordic_freq_disc.sv
// cordic_freq_disc: averages 2^LOG2_N wrapped phase steps and amplitudes of a cordic stream (valid/ready in: amp_i, phi_i, thr_i; valid/ready out: freq_o, amp_o); squelch below thr_i when CORDIC_FDISC_SQUELCH_EN is defined
module cordic_freq_disc #(
  parameter int LOG2_N = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [11:0]        amp_i,
  input  logic signed [10:0] phi_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [11:0]        thr_i,
  output logic signed [10:0] freq_o,
  output logic [11:0]        amp_o,
  output logic               valid_o,
  input  logic               ready_i
);
  typedef enum logic [1:0] {SEED, ACCUM, HOLD} state_t;
  state_t state;
  logic [10:0] prev, d;
  logic [10+LOG2_N:0] facc, fsum;
  logic [11+LOG2_N:0] aacc, asum;
  logic [LOG2_N-1:0] cnt;
  logic xfer, squelch;
  assign ready_o = state != HOLD;
  assign xfer = valid_i && ready_o;
  assign d = phi_i - prev;
  assign fsum = facc + {{LOG2_N{d[10]}}, d};
  assign asum = aacc + {{LOG2_N{1'b0}}, amp_i};
`ifdef CORDIC_FDISC_SQUELCH_EN
  assign squelch = amp_i < thr_i;
`else
  assign squelch = 1'b0 && (amp_i < thr_i);
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= SEED;
      prev    <= '0;
      facc    <= '0;
      aacc    <= '0;
      cnt     <= '0;
      freq_o  <= '0;
      amp_o   <= '0;
      valid_o <= 1'b0;
    end else if (state == HOLD) begin
      if (ready_i) begin
        state   <= ACCUM;
        valid_o <= 1'b0;
      end
    end else if (xfer) begin
      if (squelch) begin
        state <= SEED;
        facc  <= '0;
        aacc  <= '0;
        cnt   <= '0;
      end else if (state == SEED) begin
        prev  <= phi_i;
        state <= ACCUM;
      end else begin
        prev <= phi_i;
        if (&cnt) begin
          freq_o  <= fsum[10+LOG2_N:LOG2_N];
          amp_o   <= asum[11+LOG2_N:LOG2_N];
          valid_o <= 1'b1;
          state   <= HOLD;
          facc    <= '0;
          aacc    <= '0;
          cnt     <= '0;
        end else begin
          facc <= fsum;
          aacc <= asum;
          cnt  <= cnt + LOG2_N'(1);
        end
      end
    end
  end
endmodule
